// File: rtl/data_arith_imm_decode_pkg.sv
// rtl/data_arith_imm_decode_pkg.sv - shared types for the immediate decode stage
package data_arith_imm_decode_pkg;

  // Shared control bundle: single clock plus asynchronous active-low reset.
  typedef struct packed {
    logic clock;
    logic reset;
  } Data_Control_Control_T;

  // Extension mode handed to the downstream extend stage.
  typedef enum logic {
    SU_UNSIGNED = 1'b0,
    SU_SIGNED   = 1'b1
  } Data_Arith_SignedUnsigned_T;

  // MIPS primary opcodes (insn[31:26]) that carry an immediate or shamt.
  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00,
    OP_J     = 6'h02,
    OP_JAL   = 6'h03,
    OP_BEQ   = 6'h04,
    OP_BNE   = 6'h05,
    OP_ADDI  = 6'h08,
    OP_ADDIU = 6'h09,
    OP_SLTI  = 6'h0A,
    OP_SLTIU = 6'h0B,
    OP_ANDI  = 6'h0C,
    OP_ORI   = 6'h0D,
    OP_XORI  = 6'h0E,
    OP_LUI   = 6'h0F,
    OP_LW    = 6'h23,
    OP_SW    = 6'h2B
  } Data_Arith_Opcode_T;

  // The raw field is always 16 bits; wider outputs are zero-padded at the top.
  localparam int RAW_IMM_W = 16;

  // One decoded instruction as it travels through the skid buffer.
  typedef struct packed {
    logic [RAW_IMM_W-1:0]       imm;
    Data_Arith_SignedUnsigned_T sign;
    logic                       is_lui;
    logic                       is_shamt;
    logic                       illegal;
  } imm_entry_t;

  localparam int ENTRY_W = $bits(imm_entry_t);

endpackage

// File: rtl/data_arith_imm_decode_if.sv
// rtl/data_arith_imm_decode_if.sv - instruction-in / immediate-out handshake bundle
interface data_arith_imm_decode_if
  import data_arith_imm_decode_pkg::*;
#(
  parameter int INSN_W = 32,
  parameter int IMM_W  = 16,
  parameter int CNT_W  = 8
);
  logic                       in_valid;
  logic                       in_ready;
  logic [INSN_W-1:0]          insn;
  logic                       out_valid;
  logic                       out_ready;
  logic [IMM_W-1:0]           imm;
  Data_Arith_SignedUnsigned_T sign;
  logic                       is_lui;
  logic                       is_shamt;
  logic                       illegal;
  logic [CNT_W-1:0]           illegal_count;

  // Upstream fetch / downstream extend side (drives instructions, accepts results).
  modport master (
    output in_valid, insn, out_ready,
    input  in_ready, out_valid, imm, sign, is_lui, is_shamt, illegal, illegal_count
  );

  // The decode stage itself.
  modport slave (
    input  in_valid, insn, out_ready,
    output in_ready, out_valid, imm, sign, is_lui, is_shamt, illegal, illegal_count
  );
endinterface

// File: rtl/data_arith_imm_decode_skid.sv
// rtl/data_arith_imm_decode_skid.sv - generic 2-entry valid/ready skid buffer
module data_arith_imm_decode_skid #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_flush,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data
);
  logic         r_out_valid;
  logic [W-1:0] r_out_data;
  logic         r_skid_valid;
  logic [W-1:0] r_skid_data;
  logic         w_in_xfer;
  logic         w_out_free;

  // Ready is a pure function of registered state so it never combinationally
  // depends on the downstream ready.
  assign o_ready    = !r_skid_valid;
  assign o_valid    = r_out_valid;
  assign o_data     = r_out_data;
  assign w_in_xfer  = i_valid && !r_skid_valid;
  assign w_out_free = !r_out_valid || i_ready;

  // Output register refills from the skid entry first, then from the input;
  // on a stall the output holds and a new word parks in the skid entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
    end else if (i_flush) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (w_out_free) begin
      if (r_skid_valid) begin
        r_out_data   <= r_skid_data;
        r_out_valid  <= 1'b1;
        r_skid_valid <= 1'b0;
      end else begin
        r_out_valid <= w_in_xfer;
        if (w_in_xfer) begin
          r_out_data <= i_data;
        end
      end
    end else if (w_in_xfer) begin
      r_skid_data  <= i_data;
      r_skid_valid <= 1'b1;
    end
  end
endmodule

// File: rtl/data_arith_imm_decode.sv
// rtl/data_arith_imm_decode.sv - MIPS immediate/shamt decode with skid-buffered output
module data_arith_imm_decode
  import data_arith_imm_decode_pkg::*;
#(
  parameter int INSN_W = 32,
  parameter int IMM_W  = 16,
  parameter int CNT_W  = 8
) (
  input  Data_Control_Control_T   ctrl,
  input  logic                    flush,
  data_arith_imm_decode_if.slave  bus
);
  logic             w_clk;
  logic             w_rst_n;
  logic [5:0]       w_op;
  imm_entry_t       w_dec;
  imm_entry_t       w_out_entry;
  logic [ENTRY_W-1:0] w_out_data;
  logic             w_in_xfer;
  logic [CNT_W-1:0] r_illegal_count;
  logic             w_unused;

  assign w_clk     = ctrl.clock;
  assign w_rst_n   = ctrl.reset;
  assign w_op      = bus.insn[INSN_W-1 -: 6];
  assign w_in_xfer = bus.in_valid && bus.in_ready;
  // rs/rt fields are never part of the immediate.
  assign w_unused  = ^bus.insn[25:16];

  // Opcode decode: pick the field and extension mode, flag unknown opcodes.
  always_comb begin
    w_dec = '{imm: '0, sign: SU_UNSIGNED, is_lui: 1'b0, is_shamt: 1'b0, illegal: 1'b0};
    case (w_op)
      OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_LW, OP_SW: begin
        w_dec.imm  = bus.insn[15:0];
        w_dec.sign = SU_SIGNED;
      end
      OP_ANDI, OP_ORI, OP_XORI, OP_J, OP_JAL: begin
        w_dec.imm = bus.insn[15:0];
      end
      OP_LUI: begin
        w_dec.imm    = bus.insn[15:0];
        w_dec.is_lui = 1'b1;
      end
      OP_RTYPE: begin
        w_dec.imm      = {11'd0, bus.insn[10:6]};
        w_dec.is_shamt = 1'b1;
      end
      default: begin
        w_dec.illegal = 1'b1;
      end
    endcase
  end

  data_arith_imm_decode_skid #(.W(ENTRY_W)) u_skid (
    .clk     (w_clk),
    .rst_n   (w_rst_n),
    .i_flush (flush),
    .i_valid (bus.in_valid),
    .o_ready (bus.in_ready),
    .i_data  (w_dec),
    .o_valid (bus.out_valid),
    .i_ready (bus.out_ready),
    .o_data  (w_out_data)
  );

  assign w_out_entry  = imm_entry_t'(w_out_data);
  assign bus.imm      = IMM_W'(w_out_entry.imm);
  assign bus.sign     = w_out_entry.sign;
  assign bus.is_lui   = w_out_entry.is_lui;
  assign bus.is_shamt = w_out_entry.is_shamt;
  assign bus.illegal  = w_out_entry.illegal;
  assign bus.illegal_count = r_illegal_count;

  // Count accepted illegal words, saturating; a flush drops the word uncounted.
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_illegal_count <= '0;
    end else if (w_in_xfer && !flush && w_dec.illegal && (r_illegal_count != '1)) begin
      r_illegal_count <= r_illegal_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_data_arith_imm_decode.sv
// tb/tb_data_arith_imm_decode.sv - randomized scoreboard bench for the immediate decode stage
module tb_data_arith_imm_decode;
  import data_arith_imm_decode_pkg::*;

  logic clk;
  logic rst_n;
  logic flush;
  Data_Control_Control_T ctrl;

  int n_checks = 0;
  int n_fail   = 0;

  logic [19:0] q[$];
  logic [15:0] out_log[$];
  int          m_cnt = 0;

  data_arith_imm_decode_if bus ();

  assign ctrl = {clk, rst_n};

  data_arith_imm_decode dut (
    .ctrl  (ctrl),
    .flush (flush),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected entry {imm, sign, is_lui, is_shamt, illegal} straight from the opcode table.
  function automatic logic [19:0] ref_dec(input logic [31:0] w);
    logic [5:0] op;
    op = w[31:26];
    if (op inside {6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h23, 6'h2B})
      return {w[15:0], SU_SIGNED, 3'b000};
    if (op inside {6'h0C, 6'h0D, 6'h0E, 6'h02, 6'h03})
      return {w[15:0], SU_UNSIGNED, 3'b000};
    if (op == 6'h0F)
      return {w[15:0], SU_UNSIGNED, 3'b100};
    if (op == 6'h00)
      return {11'd0, w[10:6], SU_UNSIGNED, 3'b010};
    return {16'h0000, SU_UNSIGNED, 3'b001};
  endfunction

  // Scoreboard: a FIFO of at most two entries stands for everything held inside the block.
  always @(negedge clk) begin
    logic [19:0] got;
    logic [19:0] ex;
    logic        m_in;
    logic        m_out;
    if (!rst_n) begin
      q.delete();
      m_cnt = 0;
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_in_ready", 32'(bus.in_ready), 32'd1);
      check("rst_count", 32'(bus.illegal_count), 32'd0);
    end else begin
      check("out_valid", 32'(bus.out_valid), 32'(q.size() > 0));
      check("in_ready", 32'(bus.in_ready), 32'(q.size() < 2));
      check("count", 32'(bus.illegal_count), 32'(m_cnt));
      got = {bus.imm, bus.sign, bus.is_lui, bus.is_shamt, bus.illegal};
      if (q.size() > 0) check("entry", 32'(got), 32'(q[0]));
      m_in  = bus.in_valid && (q.size() < 2) && !flush;
      m_out = (q.size() > 0) && bus.out_ready;
      if (m_out) begin
        out_log.push_back(q[0][19:4]);
        void'(q.pop_front());
      end
      if (flush) begin
        q.delete();
      end else if (m_in) begin
        ex = ref_dec(bus.insn);
        q.push_back(ex);
        if (ex[0] && m_cnt < 255) m_cnt++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_one(input logic [31:0] w);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.insn     = w;
    while (!bus.in_ready && n < 50) begin
      tick();
      n++;
    end
    check("send_timeout", 32'(n < 50), 32'd1);
    tick();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] exp_ord[3];
    logic [5:0]  ops[15];
    logic [31:0] r;
    logic [5:0]  op;

    rst_n = 1'b0;
    flush = 1'b0;
    bus.in_valid  = 1'b0;
    bus.insn      = '0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    check("reset_imm", 32'(bus.imm), 32'h0);
    check("reset_sign", 32'(bus.sign), 32'(SU_UNSIGNED));
    rst_n = 1'b1;
    tick();

    // Basic decode with free-flowing output.
    bus.out_ready = 1'b1;
    send_one(32'h2008FFFB);
    check("addi_valid", 32'(bus.out_valid), 32'd1);
    check("addi_imm", 32'(bus.imm), 32'hFFFB);
    check("addi_sign", 32'(bus.sign), 32'(SU_SIGNED));
    send_one(32'h3508FFFB);
    check("ori_imm", 32'(bus.imm), 32'hFFFB);
    check("ori_sign", 32'(bus.sign), 32'(SU_UNSIGNED));
    send_one(32'h3C081234);
    check("lui_imm", 32'(bus.imm), 32'h1234);
    check("lui_flag", 32'(bus.is_lui), 32'd1);
    send_one(32'h00084080);
    check("sll_imm", 32'(bus.imm), 32'h0002);
    check("sll_shamt", 32'(bus.is_shamt), 32'd1);
    check("sll_sign", 32'(bus.sign), 32'(SU_UNSIGNED));
    tick();

    // Back-pressure: one at output, one in skid, one held upstream.
    bus.out_ready = 1'b0;
    out_log.delete();
    send_one(32'h8C010004);
    send_one(32'hAC020008);
    check("stall_in_ready", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b1;
    bus.insn     = 32'h10000003;
    repeat (3) tick();
    check("stall_hold_ready", 32'(bus.in_ready), 32'd0);
    check("stall_hold_imm", 32'(bus.imm), 32'h0004);
    bus.out_ready = 1'b1;
    send_one(32'h10000003);
    repeat (4) tick();
    exp_ord = '{16'h0004, 16'h0008, 16'h0003};
    check("order_count", 32'(out_log.size()), 32'd3);
    for (int i = 0; i < 3; i++)
      check("order_imm", (i < out_log.size()) ? 32'(out_log[i]) : 32'hDEAD, 32'(exp_ord[i]));

    // Flush with both entries full.
    bus.out_ready = 1'b0;
    send_one(32'h20010001);
    send_one(32'h20020002);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_out_valid", 32'(bus.out_valid), 32'd0);
    check("flush_in_ready", 32'(bus.in_ready), 32'd1);
    // An illegal word offered during flush is dropped and not counted.
    send_one(32'h20030003);
    flush = 1'b1;
    bus.in_valid = 1'b1;
    bus.insn     = 32'hFC000000;
    tick();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    check("flush_drop_valid", 32'(bus.out_valid), 32'd0);
    check("flush_drop_count", 32'(bus.illegal_count), 32'd0);

    // Saturating illegal counter.
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.insn      = 32'hFC000000;
    tick();
    check("illegal_flag", 32'(bus.illegal), 32'd1);
    check("illegal_imm", 32'(bus.imm), 32'h0);
    repeat (299) tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    check("illegal_saturate", 32'(bus.illegal_count), 32'd255);

    // Asynchronous reset in the middle of a full stall.
    bus.out_ready = 1'b0;
    send_one(32'h24050007);
    send_one(32'h24060009);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_out_valid", 32'(bus.out_valid), 32'd0);
    check("async_in_ready", 32'(bus.in_ready), 32'd1);
    check("async_count", 32'(bus.illegal_count), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Randomized traffic against the scoreboard.
    ops = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A,
            6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B};
    for (int i = 0; i < 2000; i++) begin
      r = $urandom();
      if ($urandom_range(0, 4) == 0) op = r[31:26];
      else op = ops[$urandom_range(0, 14)];
      bus.insn      = {op, r[25:0]};
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      flush         = ($urandom_range(0, 31) == 0);
      tick();
    end
    bus.in_valid  = 1'b0;
    flush         = 1'b0;
    bus.out_ready = 1'b1;
    repeat (5) tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
